// File: rtl/data_register_pkg.sv
// -----------------------------------------------------------------------------
// data_register_pkg
// Project-wide constants shared by the Hack-style datapath blocks.
// No ports; import with `import data_register_pkg::*;`.
// -----------------------------------------------------------------------------
package data_register_pkg;

    // Native data word width of the Hack machine.
    localparam int unsigned HACK_WORD_WIDTH = 16;

endpackage : data_register_pkg

// File: rtl/data_bit.sv
// -----------------------------------------------------------------------------
// data_bit
// Single-bit storage cell: a flop with a synchronous active-low reset to a
// per-cell reset value, plus a hold/load select in front of the D input.
//
// Ports:
//   clk    in   system clock, rising-edge active
//   rst_n  in   synchronous active-low reset (dominates load)
//   load   in   1 = capture `in` at the next rising edge, 0 = hold
//   in     in   data bit to store
//   out    out  stored bit, driven directly from the flop
// -----------------------------------------------------------------------------
module data_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic in,
    output logic out
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= RESET_BIT;
        end else if (load) begin
            out <= in;
        end
    end

endmodule : data_bit

// File: rtl/data_register.sv
// -----------------------------------------------------------------------------
// data_register
// Parameterised clocked register with load enable. Basic state element for
// the A/D registers, the PC and RAM cells. Output comes straight from flops;
// there is no combinational path from `in` to `out`.
//
// Parameters:
//   WIDTH        data width in bits (>= 1), defaults to the Hack word width
//   RESET_VALUE  value loaded on reset
//
// Ports:
//   clk    in   system clock, rising-edge active
//   rst_n  in   synchronous active-low reset (dominates load)
//   load   in   1 = capture `in` at the next rising edge, 0 = hold
//   in     in   [WIDTH-1:0] data to store
//   out    out  [WIDTH-1:0] current stored value
// -----------------------------------------------------------------------------
module data_register
    import data_register_pkg::*;
#(
    parameter int unsigned           WIDTH       = HACK_WORD_WIDTH,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    // One cell per bit; each cell takes its own slice of the reset value so
    // arbitrary reset patterns need no extra logic.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        data_bit #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load),
            .in    (in[i]),
            .out   (out[i])
        );
    end

endmodule : data_register

// File: tb/tb_data_register.sv
// -----------------------------------------------------------------------------
// tb_data_register
// Directed bench for data_register: default 16-bit instance and an 8-bit
// instance with a non-zero reset value.
// -----------------------------------------------------------------------------
module tb_data_register;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] in;
    logic [15:0] out;

    logic        rst8_n;
    logic        load8;
    logic [7:0]  in8;
    logic [7:0]  out8;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    data_register u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .in    (in),
        .out   (out)
    );

    data_register #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .rst_n (rst8_n),
        .load  (load8),
        .in    (in8),
        .out   (out8)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        load   = 1'b1;
        in     = 16'hFFFF;
        rst8_n = 1'b0;
        load8  = 1'b0;
        in8    = 8'h00;

        // Reset with load active: `in` must be ignored.
        step();
        check("reset_edge1", out, 16'h0000);
        step();
        check("reset_edge2", out, 16'h0000);

        // Load then hold for three edges.
        rst_n = 1'b1;
        load  = 1'b1;
        in    = 16'hAAAA;
        step();
        check("load_aaaa", out, 16'hAAAA);
        load = 1'b0;
        in   = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_aaaa", out, 16'hAAAA);
        end

        // Load / hold / load sequence.
        load = 1'b1;
        in   = 16'h5555;
        step();
        check("load_5555", out, 16'h5555);
        load = 1'b0;
        in   = 16'hFFFF;
        step();
        check("hold_5555", out, 16'h5555);
        load = 1'b1;
        in   = 16'h1234;
        #2;
        check("no_comb_path", out, 16'h5555);
        step();
        check("load_1234", out, 16'h1234);

        // Back-to-back loads.
        in = 16'h0001;
        step();
        check("b2b_0001", out, 16'h0001);
        in = 16'h8000;
        step();
        check("b2b_8000", out, 16'h8000);
        in = 16'hFFFF;
        step();
        check("b2b_ffff", out, 16'hFFFF);

        // Mid-operation reset pulse, then release with a load.
        in = 16'h1234;
        step();
        check("pre_rst_1234", out, 16'h1234);
        rst_n = 1'b0;
        load  = 1'b0;
        step();
        check("mid_reset", out, 16'h0000);
        rst_n = 1'b1;
        load  = 1'b1;
        in    = 16'hBEEF;
        step();
        check("post_rst_beef", out, 16'hBEEF);

        // Reset dominates load with a non-zero input.
        rst_n = 1'b0;
        in    = 16'h1234;
        step();
        check("rst_over_load", out, 16'h0000);
        rst_n = 1'b1;
        load  = 1'b0;

        // 8-bit instance, reset value A5.
        rst8_n = 1'b0;
        load8  = 1'b1;
        in8    = 8'h3C;
        step();
        check("w8_reset", {8'h00, out8}, 16'h00A5);
        rst8_n = 1'b1;
        step();
        check("w8_load_3c", {8'h00, out8}, 16'h003C);

        // Glitches on `in` between edges; only the settled value is taken.
        in8 = 8'hFF;
        #2;
        in8 = 8'h00;
        #2;
        check("w8_glitch_hold", {8'h00, out8}, 16'h003C);
        in8 = 8'h96;
        step();
        check("w8_settled_96", {8'h00, out8}, 16'h0096);

        load8 = 1'b0;
        in8   = 8'h11;
        step();
        check("w8_hold_96", {8'h00, out8}, 16'h0096);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_data_register

// File: doc/data_register.md
Name: data_register

Overview:
- Parameterised clocked storage register with a load enable. Default width is 16 bits (Hack-style data word).
- Used as the basic state element for the A/D registers, the PC and RAM cells in the upper hierarchy.
- Captures `in` on a rising clock edge when `load` is high; otherwise holds its value.
- Output is the registered value, with no combinational path from `in` to `out`.

Parameters:
- WIDTH, 16, data width in bits (must be ≥1).
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into the register on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- load  input  1  load enable; 1 = capture `in` at next rising edge.
- in  input  WIDTH  data to store.
- out  output  WIDTH  current stored value, driven directly from flops.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-low (rst_n); no asynchronous reset path.
- Priority at each rising edge of clk:
  1. rst_n==0 → out <= RESET_VALUE.
  2. else if load==1 → out <= in.
  3. else → out holds its previous value.
- Reset dominates load: rst_n==0 and load==1 on the same edge yields RESET_VALUE, and `in` is ignored.
- Latency is one cycle. A value presented with load=1 before edge N appears on `out` just after edge N and stays until the next loading or reset edge.
- Changes on `in` or `load` between edges have no effect on `out`.
- Back-to-back loads on consecutive edges are supported; each edge captures the `in` present at that edge.
- Before the first reset edge, `out` is undefined (X in simulation). The bench must apply reset before checking.
- Deasserting reset mid-operation: the first edge with rst_n==1 follows normal load/hold rules.
- All WIDTH bits update together; there are no partial or byte writes.
- No X-propagation suppression is required.

Decomposition:
- Shared package: no typedefs needed. Optionally define a constant HACK_WORD_WIDTH = 16 in the project-wide package; WIDTH defaults to it.
- Sub-module data_bit: a 1-bit cell containing a DFF with sync active-low reset, a per-bit reset value and a hold/load mux.
- data_register instantiates WIDTH data_bit cells via generate, passing RESET_VALUE[i] to cell i.
- The flat behavioural form is an acceptable equivalent if synthesis results match.

Test Plan:
- Reset: rst_n=0 for 2 edges with load=1, in=16'hFFFF → out==16'h0000 after the first edge; `in` is ignored.
- Load then hold: load=1, in=16'hAAAA at edge → out==16'hAAAA. Then load=0, in=16'h5555 for 3 edges → out stays 16'hAAAA.
- Sequence:
  - load 16'h5555 → out==16'h5555.
  - load=0, in=16'hFFFF → out holds 16'h5555.
  - load=1, in=16'h1234 → out==16'h1234 one edge later.
- Back-to-back loads: 16'h0001, 16'h8000, 16'hFFFF on consecutive edges → out follows each value with one-cycle latency.
- Mid-operation reset: out==16'h1234, then pulse rst_n=0 for one edge with load=0 → out==16'h0000. Release with load=1, in=16'hBEEF → out==16'hBEEF next edge.
- Parameter check: WIDTH=8, RESET_VALUE=8'hA5.
  - Reset → out==8'hA5.
  - Load 8'h3C → out==8'h3C.
  - Mid-edge glitch on `in` with load=1 that settles before the edge → only the settled value is captured.
